// File: rtl/mmap_ext.sv
`default_nettype none
// ============================================================================
// Module   : mmap_ext
// Purpose  : Z80 memory/port mapper with extended RAM banking, +3 paging
//            and M1-driven TR-DOS ROM auto-paging.
// Revision : 1.0 - initial release
// ============================================================================
module mmap_ext #(
    parameter int BANK_BITS    = 3,
    parameter int ENABLE_1FFD  = 1,
    parameter int ENABLE_TRDOS = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   m0,
    input  logic                   hold,
    input  logic [15:0]            address,
    output logic [7:0]             i_data,
    input  logic [7:0]             o_data,
    input  logic                   we,
    output logic [7:0]             portin,
    input  logic                   portrd,
    input  logic                   portwe,
    output logic [15:0]            rom_address,
    output logic [BANK_BITS+13:0]  ram_address,
    input  logic [7:0]             rom_idata,
    input  logic [7:0]             ram_idata,
    output logic                   ram_we,
    output logic                   vidpage,
    output logic [2:0]             border,
    input  logic [7:0]             kbd,
    input  logic                   mic,
    output logic                   spkr,
    output logic [3:0]             ay_reg,
    output logic [7:0]             ay_data_o,
    input  logic [7:0]             ay_data_i,
    output logic                   ay_req,
    output logic                   sd_signal,
    output logic [1:0]             sd_cmd,
    input  logic [7:0]             sd_din,
    output logic [7:0]             sd_out,
    input  logic                   sd_busy,
    input  logic                   sd_timeout,
    output logic                   trdos_active
);

    logic [7:0]           r_port7ffd;
    logic [7:0]           r_port1ffd;
    logic                 w_lock;
    logic                 w_special;
    logic                 w_plus3_rom;
    logic                 w_wprot;
    logic [BANK_BITS-1:0] w_sel_bank;
    logic [BANK_BITS-1:0] w_bank7;
    logic [BANK_BITS-1:0] w_bank;
    logic [2:0]           w_special_bank;
    logic [1:0]           w_base_page;
    logic [1:0]           w_rom_page;
    logic                 w_wr;
    logic                 w_sel_fffd;
    logic                 w_sel_bffd;
    logic                 w_sel_0f;
    logic                 w_sel_1f;
    logic                 w_sel_1ffd;
    logic                 w_sel_7ffd;
    logic                 w_sel_ula;
    logic                 w_sel_low;
    logic                 w_unused;

    assign w_unused = &{1'b0, portrd, kbd[7:5]};

    // With 1 MB of RAM, bit 5 of 7FFD becomes a bank bit and locking is lost.
    assign w_lock      = (BANK_BITS == 6) ? 1'b0 : r_port7ffd[5];
    assign w_special   = (ENABLE_1FFD != 0) && r_port1ffd[0];
    assign w_plus3_rom = (ENABLE_1FFD != 0) && r_port1ffd[2];
    assign w_wprot     = (BANK_BITS == 3) && r_port7ffd[7];

    generate
        if (BANK_BITS == 3) begin : g_bank3
            assign w_sel_bank = r_port7ffd[2:0];
        end else if (BANK_BITS == 4) begin : g_bank4
            assign w_sel_bank = {r_port7ffd[6], r_port7ffd[2:0]};
        end else if (BANK_BITS == 5) begin : g_bank5
            assign w_sel_bank = {r_port7ffd[7:6], r_port7ffd[2:0]};
        end else begin : g_bank6
            assign w_sel_bank = {r_port7ffd[5], r_port7ffd[7:6], r_port7ffd[2:0]};
        end
    endgenerate

    assign w_bank7     = w_lock ? '0 : w_sel_bank;
    assign w_base_page = w_plus3_rom ? {1'b1, r_port7ffd[4]}
                                     : {1'b0, w_lock | r_port7ffd[4]};
    assign w_rom_page  = trdos_active ? 2'd2 : w_base_page;
    assign rom_address = {w_rom_page, address[13:0]};
    assign vidpage     = w_lock ? 1'b0 : r_port7ffd[3];

    always_comb begin
        w_special_bank = {1'b1, address[15:14]};
        case (r_port1ffd[2:1])
            2'b00:   w_special_bank = {1'b0, address[15:14]};
            2'b01:   w_special_bank = {1'b1, address[15:14]};
            2'b10:   if (address[15:14] == 2'b11) w_special_bank = 3'd3;
            default: begin
                case (address[15:14])
                    2'b00:   w_special_bank = 3'd4;
                    2'b01:   w_special_bank = 3'd7;
                    2'b10:   w_special_bank = 3'd6;
                    default: w_special_bank = 3'd3;
                endcase
            end
        endcase
    end

    always_comb begin
        w_bank = '0;
        ram_we = 1'b0;
        i_data = ram_idata;
        if (w_special) begin
            w_bank = BANK_BITS'(w_special_bank);
            ram_we = we;
        end else begin
            case (address[15:14])
                2'b00: i_data = rom_idata;
                2'b01: begin
                    w_bank = BANK_BITS'(3'd5);
                    ram_we = we;
                end
                2'b10: begin
                    w_bank = BANK_BITS'(3'd2);
                    ram_we = we;
                end
                default: begin
                    w_bank = w_bank7;
                    ram_we = we && !w_wprot;
                end
            endcase
        end
    end

    assign ram_address = {w_bank, address[13:0]};

    assign w_sel_fffd = (address == 16'hFFFD);
    assign w_sel_bffd = (address == 16'hBFFD);
    assign w_sel_0f   = (address[7:0] == 8'h0F);
    assign w_sel_1f   = (address[7:0] == 8'h1F);
    assign w_sel_1ffd = (address == 16'h1FFD);
    assign w_sel_7ffd = (address[7:0] == 8'hFD);
    assign w_sel_ula  = !address[0];
    assign w_sel_low  = (address[7:5] == 3'b000);

    always_comb begin
        portin = 8'hFF;
        if (w_sel_fffd)       portin = {4'h0, ay_reg};
        else if (w_sel_bffd)  portin = ay_data_i;
        else if (w_sel_0f)    portin = sd_din;
        else if (w_sel_1f)    portin = {sd_timeout, 6'b0, sd_busy};
        else if (w_sel_1ffd)  portin = r_port1ffd;
        else if (w_sel_7ffd)  portin = r_port7ffd;
        else if (w_sel_ula)   portin = {1'b1, mic, 1'b1, kbd[4:0]};
        else if (w_sel_low)   portin = 8'h00;
    end

    assign w_wr = portwe && hold;

    // sd_signal is forced low the cycle after it rises, so it is a single pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_port7ffd <= 8'h00;
            r_port1ffd <= 8'h00;
            ay_reg     <= 4'h0;
            ay_data_o  <= 8'h00;
            ay_req     <= 1'b0;
            sd_signal  <= 1'b0;
            sd_cmd     <= 2'b00;
            sd_out     <= 8'h00;
            border     <= 3'b000;
            spkr       <= 1'b0;
        end else begin
            sd_signal <= 1'b0;
            if (w_wr) begin
                if (w_sel_fffd) begin
                    ay_reg <= o_data[3:0];
                end else if (w_sel_bffd) begin
                    ay_data_o <= o_data;
                    ay_req    <= ~ay_req;
                end else if (w_sel_0f) begin
                    sd_out    <= o_data;
                    sd_cmd    <= 2'd1;
                    sd_signal <= !sd_signal;
                end else if (w_sel_1f) begin
                    sd_cmd    <= o_data[1:0];
                    sd_signal <= !sd_signal;
                end else if (w_sel_1ffd) begin
                    if (!w_lock && (ENABLE_1FFD != 0)) r_port1ffd <= o_data;
                end else if (w_sel_7ffd) begin
                    if (!w_lock) r_port7ffd <= o_data;
                end else if (w_sel_ula) begin
                    border <= o_data[2:0];
                    spkr   <= o_data[4] ^ o_data[3];
                end
            end
        end
    end

    generate
        if (ENABLE_TRDOS != 0) begin : g_trdos
            typedef enum logic [0:0] {
                TR_OFF = 1'b0,
                TR_ON  = 1'b1
            } trdos_state_t;

            trdos_state_t r_state;
            trdos_state_t w_state_next;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) r_state <= TR_OFF;
                else          r_state <= w_state_next;
            end

            // Entry is judged on the ROM page that would be mapped without TR-DOS.
            always_comb begin
                w_state_next = r_state;
                case (r_state)
                    TR_OFF: if (m0 && hold && (address[15:8] == 8'h3D) && (w_base_page == 2'd1))
                                w_state_next = TR_ON;
                    TR_ON:  if (m0 && hold && (address[15:14] != 2'b00))
                                w_state_next = TR_OFF;
                    default: w_state_next = TR_OFF;
                endcase
            end

            assign trdos_active = (r_state == TR_ON);
        end else begin : g_no_trdos
            assign trdos_active = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mmap_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmap_ext
// Purpose  : Self-checking bench for mmap_ext (128K and 512K builds) against
//            a behavioural memory/port map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmap_ext;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0 = 1'b0, hold = 1'b1, we = 1'b0, portrd = 1'b0, portwe = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  o_data = 8'h00, rom_idata = 8'hA5, ram_idata = 8'h3C;
    logic [7:0]  kbd = 8'h1F, ay_data_i = 8'h00, sd_din = 8'h00;
    logic        mic = 1'b0, sd_busy = 1'b0, sd_timeout = 1'b0;

    logic [7:0]  i_data3, portin3, ay_data_o3, sd_out3;
    logic [15:0] rom_address3;
    logic [16:0] ram_address3;
    logic        ram_we3, vidpage3, spkr3, ay_req3, sd_signal3, trdos3;
    logic [2:0]  border3;
    logic [3:0]  ay_reg3;
    logic [1:0]  sd_cmd3;

    logic [7:0]  i_data5, portin5, ay_data_o5, sd_out5;
    logic [15:0] rom_address5;
    logic [18:0] ram_address5;
    logic        ram_we5, vidpage5, spkr5, ay_req5, sd_signal5, trdos5;
    logic [2:0]  border5;
    logic [3:0]  ay_reg5;
    logic [1:0]  sd_cmd5;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_p7, m_p1, m_ay_data, m_sd_out;
    logic [3:0] m_ay_reg;
    logic [1:0] m_sd_cmd;
    logic [2:0] m_border;
    logic       m_ay_req, m_sd_sig, m_spkr, m_trdos;

    int sp_tbl [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 3, 4, 7, 6, 3};

    always #5 clock = ~clock;

    mmap_ext #(.BANK_BITS(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .m0(m0), .hold(hold), .address(address),
        .i_data(i_data3), .o_data(o_data), .we(we), .portin(portin3), .portrd(portrd),
        .portwe(portwe), .rom_address(rom_address3), .ram_address(ram_address3),
        .rom_idata(rom_idata), .ram_idata(ram_idata), .ram_we(ram_we3), .vidpage(vidpage3),
        .border(border3), .kbd(kbd), .mic(mic), .spkr(spkr3), .ay_reg(ay_reg3),
        .ay_data_o(ay_data_o3), .ay_data_i(ay_data_i), .ay_req(ay_req3),
        .sd_signal(sd_signal3), .sd_cmd(sd_cmd3), .sd_din(sd_din), .sd_out(sd_out3),
        .sd_busy(sd_busy), .sd_timeout(sd_timeout), .trdos_active(trdos3)
    );

    mmap_ext #(.BANK_BITS(5)) u_dut5 (
        .clock(clock), .reset_n(reset_n), .m0(m0), .hold(hold), .address(address),
        .i_data(i_data5), .o_data(o_data), .we(we), .portin(portin5), .portrd(portrd),
        .portwe(portwe), .rom_address(rom_address5), .ram_address(ram_address5),
        .rom_idata(rom_idata), .ram_idata(ram_idata), .ram_we(ram_we5), .vidpage(vidpage5),
        .border(border5), .kbd(kbd), .mic(mic), .spkr(spkr5), .ay_reg(ay_reg5),
        .ay_data_o(ay_data_o5), .ay_data_i(ay_data_i), .ay_req(ay_req5),
        .sd_signal(sd_signal5), .sd_cmd(sd_cmd5), .sd_din(sd_din), .sd_out(sd_out5),
        .sd_busy(sd_busy), .sd_timeout(sd_timeout), .trdos_active(trdos5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit mdl_special();
        return m_p1[0];
    endfunction

    function automatic int mdl_base_page();
        if (m_p1[2]) return 2 + int'(m_p7[4]);
        return m_p7[5] ? 1 : int'(m_p7[4]);
    endfunction

    function automatic int mdl_bank(input int bb, input logic [15:0] a);
        int win = int'(a[15:14]);
        if (mdl_special()) return sp_tbl[int'(m_p1[2:1]) * 4 + win];
        if (win == 1) return 5;
        if (win == 2) return 2;
        if (m_p7[5]) return 0;
        if (bb == 3) return int'(m_p7[2:0]);
        return int'(m_p7[7:6]) * 8 + int'(m_p7[2:0]);
    endfunction

    function automatic bit mdl_ram_we(input int bb, input logic [15:0] a);
        int win = int'(a[15:14]);
        if (!we) return 1'b0;
        if (mdl_special()) return 1'b1;
        if (win == 0) return 1'b0;
        if (win == 3 && bb == 3 && m_p7[7]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] mdl_portin(input logic [15:0] a);
        if (a == 16'hFFFD) return {4'h0, m_ay_reg};
        if (a == 16'hBFFD) return ay_data_i;
        if (a[7:0] == 8'h0F) return sd_din;
        if (a[7:0] == 8'h1F) return {sd_timeout, 6'b0, sd_busy};
        if (a == 16'h1FFD) return m_p1;
        if (a[7:0] == 8'hFD) return m_p7;
        if (!a[0]) return {1'b1, mic, 1'b1, kbd[4:0]};
        if (a[7:5] == 3'b000) return 8'h00;
        return 8'hFF;
    endfunction

    task automatic model_reset();
        m_p7 = 0; m_p1 = 0; m_ay_data = 0; m_sd_out = 0; m_ay_reg = 0; m_sd_cmd = 0;
        m_border = 0; m_ay_req = 0; m_sd_sig = 0; m_spkr = 0; m_trdos = 0;
    endtask

    task automatic model_update();
        bit nxt_tr;
        bit sdw;
        nxt_tr = m_trdos;
        sdw = 1'b0;
        if (m0 && hold) begin
            if (!m_trdos && address[15:8] == 8'h3D && mdl_base_page() == 1) nxt_tr = 1'b1;
            else if (m_trdos && address[15:14] != 2'b00) nxt_tr = 1'b0;
        end
        if (portwe && hold) begin
            if (address == 16'hFFFD) m_ay_reg = o_data[3:0];
            else if (address == 16'hBFFD) begin m_ay_data = o_data; m_ay_req = !m_ay_req; end
            else if (address[7:0] == 8'h0F) begin m_sd_out = o_data; m_sd_cmd = 2'd1; sdw = 1'b1; end
            else if (address[7:0] == 8'h1F) begin m_sd_cmd = o_data[1:0]; sdw = 1'b1; end
            else if (address == 16'h1FFD) begin if (!m_p7[5]) m_p1 = o_data; end
            else if (address[7:0] == 8'hFD) begin if (!m_p7[5]) m_p7 = o_data; end
            else if (!address[0]) begin m_border = o_data[2:0]; m_spkr = o_data[4] ^ o_data[3]; end
        end
        m_sd_sig = sdw && !m_sd_sig;
        m_trdos = nxt_tr;
    endtask

    task automatic compare_all();
        int rp;
        rp = m_trdos ? 2 : mdl_base_page();
        check("rom_address", {16'h0, rom_address3}, rp * 16384 + int'(address[13:0]));
        check("rom_address5", {16'h0, rom_address5}, rp * 16384 + int'(address[13:0]));
        check("vidpage", {31'h0, vidpage3}, {31'h0, m_p7[5] ? 1'b0 : m_p7[3]});
        check("border", {29'h0, border3}, {29'h0, m_border});
        check("spkr", {31'h0, spkr3}, {31'h0, m_spkr});
        check("ay_reg", {28'h0, ay_reg3}, {28'h0, m_ay_reg});
        check("ay_data_o", {24'h0, ay_data_o3}, {24'h0, m_ay_data});
        check("ay_req", {31'h0, ay_req3}, {31'h0, m_ay_req});
        check("sd_signal", {31'h0, sd_signal3}, {31'h0, m_sd_sig});
        check("sd_cmd", {30'h0, sd_cmd3}, {30'h0, m_sd_cmd});
        check("sd_out", {24'h0, sd_out3}, {24'h0, m_sd_out});
        check("trdos_active", {31'h0, trdos3}, {31'h0, m_trdos});
        check("trdos_active5", {31'h0, trdos5}, {31'h0, m_trdos});
        check("portin", {24'h0, portin3}, {24'h0, mdl_portin(address)});
        check("portin5", {24'h0, portin5}, {24'h0, mdl_portin(address)});
        check("i_data", {24'h0, i_data3},
              {24'h0, (!mdl_special() && address[15:14] == 2'b00) ? rom_idata : ram_idata});
        check("i_data5", {24'h0, i_data5},
              {24'h0, (!mdl_special() && address[15:14] == 2'b00) ? rom_idata : ram_idata});
        check("ram_we", {31'h0, ram_we3}, {31'h0, mdl_ram_we(3, address)});
        check("ram_we5", {31'h0, ram_we5}, {31'h0, mdl_ram_we(5, address)});
        if (mdl_special() || address[15:14] != 2'b00) begin
            check("ram_address", {15'h0, ram_address3}, mdl_bank(3, address) * 16384 + int'(address[13:0]));
            check("ram_address5", {13'h0, ram_address5}, mdl_bank(5, address) * 16384 + int'(address[13:0]));
        end
    endtask

    task automatic step();
        @(negedge clock);
        compare_all();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle(input logic [15:0] a);
        portwe = 1'b0; m0 = 1'b0; we = 1'b0; hold = 1'b1; address = a;
    endtask

    task automatic port_write(input logic [15:0] a, input logic [7:0] d);
        idle(a);
        o_data = d;
        portwe = 1'b1;
        step();
        portwe = 1'b0;
    endtask

    task automatic do_async_reset();
        #2;
        portwe = 1'b0; m0 = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_border", {29'h0, border3}, 0);
        check("rst_spkr", {31'h0, spkr3}, 0);
        check("rst_ay_reg", {28'h0, ay_reg3}, 0);
        check("rst_ay_data", {24'h0, ay_data_o3}, 0);
        check("rst_ay_req", {31'h0, ay_req3}, 0);
        check("rst_sd_signal", {31'h0, sd_signal3}, 0);
        check("rst_sd_cmd", {30'h0, sd_cmd3}, 0);
        check("rst_sd_out", {24'h0, sd_out3}, 0);
        check("rst_trdos", {31'h0, trdos3}, 0);
        check("rst_vidpage", {31'h0, vidpage3}, 0);
        model_reset();
        @(negedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic rand_inputs();
        int r;
        r = int'($urandom_range(0, 11));
        hold = ($urandom_range(0, 7) != 0);
        m0 = $urandom_range(0, 1) == 1;
        we = $urandom_range(0, 1) == 1;
        portwe = ($urandom_range(0, 9) < 3);
        o_data = 8'($urandom);
        rom_idata = 8'($urandom); ram_idata = 8'($urandom); kbd = 8'($urandom);
        ay_data_i = 8'($urandom); sd_din = 8'($urandom);
        mic = $urandom_range(0, 1) == 1;
        sd_busy = $urandom_range(0, 1) == 1;
        sd_timeout = $urandom_range(0, 1) == 1;
        case (r)
            0:  address = 16'hFFFD;
            1:  address = 16'hBFFD;
            2:  address = {8'($urandom), 8'h0F};
            3:  address = {8'($urandom), 8'h1F};
            4:  address = 16'h1FFD;
            5:  address = 16'h7FFD;
            6:  address = {8'($urandom), 7'($urandom), 1'b0};
            7:  address = {8'h3D, 8'($urandom)};
            default: address = 16'($urandom);
        endcase
        if ((r == 4 || r == 5) && $urandom_range(0, 7) != 0) o_data[5] = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        idle(16'h0000);
        step();
        check("reset_rom_0000", {16'h0, rom_address3}, 32'h0000);

        port_write(16'h7FFD, 8'h17);
        idle(16'hC123);
        step();
        check("bank7_c123", {15'h0, ram_address3}, 32'h1C123);
        check("vidpage_17", {31'h0, vidpage3}, 0);
        idle(16'h0123);
        step();
        check("rom_page1", {16'h0, rom_address3}, 32'h4123);

        port_write(16'h7FFD, 8'hC3);
        idle(16'hC000);
        we = 1'b1;
        step();
        check("bank1b_512k", {13'h0, ram_address5}, 32'h6C000);
        check("we_c000_512k", {31'h0, ram_we5}, 1);
        check("wprot_c000_128k", {31'h0, ram_we3}, 0);
        port_write(16'h7FFD, 8'h23);
        port_write(16'h7FFD, 8'h07);
        idle(16'h7FFD);
        step();
        check("locked_7ffd", {24'h0, portin3}, 32'h23);

        do_async_reset();
        port_write(16'h7FFD, 8'h10);
        idle(16'h3D2F);
        m0 = 1'b1;
        step();
        check("trdos_on", {31'h0, trdos3}, 1);
        check("trdos_rom", {16'h0, rom_address3}, 32'hBD2F);
        address = 16'h8000;
        step();
        check("trdos_off", {31'h0, trdos3}, 0);

        port_write(16'h1FFD, 8'h07);
        idle(16'h4000);
        step();
        check("special_4000", {15'h0, ram_address3}, 32'h1C000);
        idle(16'h0000);
        we = 1'b1;
        step();
        check("special_we_0000", {31'h0, ram_we3}, 1);

        port_write(16'h000F, 8'h5A);
        check("sd_out_5a", {24'h0, sd_out3}, 32'h5A);
        check("sd_cmd_1", {30'h0, sd_cmd3}, 1);
        check("sd_pulse_hi", {31'h0, sd_signal3}, 1);
        idle(16'h001F);
        sd_busy = 1'b1; sd_timeout = 1'b1;
        step();
        check("sd_pulse_lo", {31'h0, sd_signal3}, 0);
        check("sd_status", {24'h0, portin3}, 32'h81);

        check("ay_req_0", {31'h0, ay_req3}, 0);
        port_write(16'hBFFD, 8'h11);
        check("ay_req_1", {31'h0, ay_req3}, 1);
        port_write(16'hBFFD, 8'h22);
        check("ay_req_2", {31'h0, ay_req3}, 0);
        do_async_reset();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
            if (i % 500 == 499) do_async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmap_ext.md
Name: mmap_ext

Overview:
- Parametrised successor to the 128K memory/port mapper.
- Sits between the Z80 core and the ROM/RAM/AY/SD/keyboard blocks.
- Decodes the 16-bit CPU address into paged ROM and RAM addresses, and decodes I/O ports.
- Adds over the 128K mapper: extended RAM banking up to 1 MB (Pentagon-style), +3 special paging via 1FFD, a 4-page ROM, and an M1-driven TR-DOS auto-paging state machine.

Parameters:
- BANK_BITS, 3, RAM bank index width. Allowed values 3, 4, 5, 6 (128K/256K/512K/1024K). ram_address width is BANK_BITS+14.
- ENABLE_1FFD, 1, when 1, port 1FFD is implemented (+3 paging); when 0, 1FFD writes are ignored.
- ENABLE_TRDOS, 1, when 1, the TR-DOS auto-paging FSM is present; when 0, trdos_active is constant 0.

Ports:
- clock  in  1  CPU clock.
- reset_n  in  1  asynchronous active-low reset.
- m0  in  1  opcode fetch (M1) cycle.
- hold  in  1  bus cycle qualifier. Port writes and FSM events are sampled only when hold=1.
- address  in  16  CPU address.
- i_data  out  8  data to CPU (combinational).
- o_data  in  8  data from CPU.
- we  in  1  memory write.
- portin  out  8  port read data (combinational).
- portrd  in  1  port read strobe.
- portwe  in  1  port write strobe.
- rom_address  out  16  {rom_page[1:0], A[13:0]}.
- ram_address  out  BANK_BITS+14  {bank, A[13:0]}.
- rom_idata / ram_idata  in  8  memory read data.
- ram_we  out  1  RAM write enable.
- vidpage  out  1  0 = screen in bank 5, 1 = screen in bank 7.
- border  out  3  border colour.
- kbd  in  8  keyboard row data.
- mic  in  1  tape input.
- spkr  out  1  beeper.
- ay_reg  out  4  AY register select.
- ay_data_o  out  8  AY write data.
- ay_data_i  in  8  AY read data.
- ay_req  out  1  toggles on each AY data write.
- sd_signal  out  1  one-cycle command pulse to the SD controller.
- sd_cmd  out  2  SD command ID.
- sd_din  in  8  data from SD.
- sd_out  out  8  data to SD.
- sd_busy  in  1  SD controller busy.
- sd_timeout  in  1  SD timeout flag.
- trdos_active  out  1  TR-DOS ROM currently paged in.

Behaviour:
- Reset (async, reset_n=0): clears port7ffd, port1ffd, trdos_active, ay_req, ay_reg, ay_data_o, sd_signal, sd_cmd, sd_out, border, spkr. All become 0.
- lock = port7ffd[5], except when BANK_BITS==6, where lock=0 and bit5 is a bank bit.
- Bank select: bank = {ext, port7ffd[2:0]}.
  - ext is 7ffd[6] for BANK_BITS=4, 7ffd[7:6] for 5, and {7ffd[5], 7ffd[7:6]} for 6.
  - When lock=1, bank = 0.
- Write protect: for BANK_BITS==3, 7ffd[7]=1 inhibits ram_we in window C000–FFFF. For BANK_BITS>3 there is no write protect.
- ROM page, in priority order:
  - trdos_active → 2.
  - 1FFD[2] set with ENABLE_1FFD → {1, 7ffd[4]}.
  - otherwise → {0, lock ? 1 : 7ffd[4]}.
- vidpage = lock ? 0 : 7ffd[3].
- Normal mapping:
  - A[15:14]=00: ROM, i_data=rom_idata, ram_we=0.
  - 01: RAM bank 5, writes allowed.
  - 10: RAM bank 2, writes allowed.
  - 11: selected bank, writes per the write-protect rule.
- Special mode (ENABLE_1FFD and 1FFD[0]=1): all four windows are RAM, writable, with banks by 1FFD[2:1]:
  - 00 → 0,1,2,3
  - 01 → 4,5,6,7
  - 10 → 4,5,6,3
  - 11 → 4,7,6,3
- Port reads, priority order, default FF:
  - FFFD → {4'h0, ay_reg}
  - BFFD → ay_data_i
  - A[7:0]=0F → sd_din
  - A[7:0]=1F → {sd_timeout, 6'b0, sd_busy}
  - 1FFD → port1ffd
  - A[7:0]=FD → port7ffd
  - A[0]=0 → {1, mic, 1, kbd[4:0]}
  - A[7:5]=0 → 00
- Port writes take effect on the posedge clock where portwe&&hold, using the same priority:
  - FFFD: ay_reg ← o_data[3:0].
  - BFFD: ay_data_o ← o_data and ay_req toggles.
  - 0F: sd_out ← o_data, sd_cmd ← 1, sd_signal=1 for exactly one cycle.
  - 1F: sd_cmd ← o_data[1:0], sd_signal pulse.
  - 1FFD: written only if !lock and ENABLE_1FFD.
  - FD: 7ffd written only if !lock.
  - A[0]=0: border ← o_data[2:0], spkr ← o_data[4]^o_data[3].
  - sd_signal returns to 0 on the next clock regardless of further writes.
- TR-DOS FSM, states OFF and ON:
  - OFF→ON on m0&&hold with A[15:8]==3D and the ROM page (excluding TR-DOS) == 1.
  - ON→OFF on m0&&hold with A[15:14]!=00.
  - Transitions register on the clock edge. The new ROM page applies from the following cycle; the triggering fetch still reads the old page.
  - A write to 7FFD does not change FSM state.
- Simultaneous events: a port write and an FSM transition in the same cycle are both applied independently.
- Reset mid-operation: reset asynchronously returns the FSM to OFF and restores the default map.

Test Plan:
- Reset, then read at 0000 → rom_address=0000. Write 7FFD=0x17 → at C000 ram_address bank 7; rom_address=4000+offset; vidpage=0.
- BANK_BITS=5: write 7FFD=0xC3 → C000 maps bank 0x1B (ram_address=0x6C000). A write at C000 asserts ram_we. 0x23 then locks; a later 7FFD write is ignored.
- ROM page 1, m0 fetch at 3D2F → next cycle trdos_active=1, rom_address=0xBD2F. m0 fetch at 8000 → trdos_active=0.
- Write 1FFD=0x07 → special 4,7,6,3: address 4000 → bank 7; writes at 0000 set ram_we.
- Port write 0F data 0x5A → sd_out=5A, sd_cmd=1, sd_signal high exactly one cycle. Read 1F with sd_busy=1, timeout=1 → 0x81.
- Two BFFD writes → ay_req toggles 0→1→0. Assert reset_n=0 asynchronously mid-cycle → all outputs 0 before the next edge.
